// File: rtl/pll_lock_sequencer.sv
// rPLL bring-up sequencer on the free-running crystal clock: pulses PLL reset, drives the
// divider selects, qualifies lock (timeout, retry limit, stability) and gates the video-domain reset.
module pll_lock_sequencer #(
    parameter int         RESET_HOLD_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT_CYCLES = 2700000,
    parameter int         LOCK_STABLE_CYCLES  = 1024,
    parameter int         MAX_RETRIES         = 3,
    parameter logic [5:0] INIT_IDIV           = 6'd8,
    parameter logic [5:0] INIT_FBDIV          = 6'd63,
    parameter logic [5:0] INIT_ODIV           = 6'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idiv,
    input  logic [5:0] cfg_fbdiv,
    input  logic [5:0] cfg_odiv,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       clk_ok,
    output logic       dom_rst_n,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1)   ? $clog2(RESET_HOLD_CYCLES)   : 1;
    localparam int TMO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int STAB_W = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]        RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        if (v == 2'd3) begin
            return v;
        end else begin
            return v + 2'd1;
        end
    endfunction

    state_t            state_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [TMO_W-1:0]  timer_r;
    logic [STAB_W-1:0] stab_cnt_r;
    logic [1:0]        retry_cnt_r;
    logic              pll_reset_r;
    logic              run_r;
    logic              cfg_ready_r;
    logic              fault_r;
    logic [5:0]        idsel_r;
    logic [5:0]        fbdsel_r;
    logic [5:0]        odsel_r;
    logic              lock_meta_r;
    logic              lock_s;
    logic              cfg_fire_s;
    logic [1:0]        retry_next_s;

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_s      <= lock_meta_r;
        end
    end

    // Handshake qualification and next retry count
    always_comb begin
        cfg_fire_s   = 1'b0;
        retry_next_s = sat_inc2(retry_cnt_r);
        if ((state_r == ST_RUN) || (state_r == ST_FAULT)) begin
            cfg_fire_s = cfg_valid & cfg_ready_r;
        end else begin
            cfg_fire_s = 1'b0;
        end
    end

    // Sequencer state, counters, divider selects and every registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HOLD;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            timer_r     <= {TMO_W{1'b0}};
            stab_cnt_r  <= {STAB_W{1'b0}};
            retry_cnt_r <= 2'd0;
            pll_reset_r <= 1'b1;
            run_r       <= 1'b0;
            cfg_ready_r <= 1'b0;
            fault_r     <= 1'b0;
            idsel_r     <= ~INIT_IDIV;
            fbdsel_r    <= ~INIT_FBDIV;
            odsel_r     <= ~INIT_ODIV;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r     <= ST_WAIT_LOCK;
                        pll_reset_r <= 1'b0;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        timer_r     <= {TMO_W{1'b0}};
                    end else begin
                        hold_cnt_r  <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_r    <= ST_STABLE;
                        stab_cnt_r <= {STAB_W{1'b0}};
                    end else if (timer_r == TMO_LAST) begin
                        retry_cnt_r <= retry_next_s;
                        timer_r     <= {TMO_W{1'b0}};
                        pll_reset_r <= 1'b1;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        if (retry_next_s == RETRY_LIMIT) begin
                            state_r     <= ST_FAULT;
                            fault_r     <= 1'b1;
                            cfg_ready_r <= 1'b1;
                        end else begin
                            state_r     <= ST_HOLD;
                        end
                    end else begin
                        timer_r <= timer_r + TMO_W'(1);
                    end
                end
                ST_STABLE: begin
                    // Any low sample restarts qualification without costing a retry
                    if (!lock_s) begin
                        state_r <= ST_WAIT_LOCK;
                        timer_r <= {TMO_W{1'b0}};
                    end else if (stab_cnt_r == STAB_LAST) begin
                        state_r     <= ST_RUN;
                        run_r       <= 1'b1;
                        cfg_ready_r <= 1'b1;
                        retry_cnt_r <= 2'd0;
                        stab_cnt_r  <= {STAB_W{1'b0}};
                    end else begin
                        stab_cnt_r <= stab_cnt_r + STAB_W'(1);
                    end
                end
                ST_RUN, ST_FAULT: begin
                    // A handshake outranks lock loss so the new dividers are never dropped
                    if (cfg_fire_s) begin
                        idsel_r     <= ~cfg_idiv;
                        fbdsel_r    <= ~cfg_fbdiv;
                        odsel_r     <= ~cfg_odiv;
                        state_r     <= ST_HOLD;
                        pll_reset_r <= 1'b1;
                        run_r       <= 1'b0;
                        cfg_ready_r <= 1'b0;
                        fault_r     <= 1'b0;
                        retry_cnt_r <= 2'd0;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                    end else if ((state_r == ST_RUN) && !lock_s) begin
                        state_r     <= ST_HOLD;
                        pll_reset_r <= 1'b1;
                        run_r       <= 1'b0;
                        cfg_ready_r <= 1'b0;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r     <= ST_HOLD;
                    pll_reset_r <= 1'b1;
                    run_r       <= 1'b0;
                    cfg_ready_r <= 1'b0;
                    fault_r     <= 1'b0;
                    hold_cnt_r  <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    assign pll_reset  = pll_reset_r;
    assign pll_idsel  = idsel_r;
    assign pll_fbdsel = fbdsel_r;
    assign pll_odsel  = odsel_r;
    assign clk_ok     = run_r;
    assign dom_rst_n  = run_r;
    assign cfg_ready  = cfg_ready_r;
    assign fault      = fault_r;
    assign retry_cnt  = retry_cnt_r;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Controller for the rPLL that generates the DVI pixel and serial clocks. It runs from the free-running 27 MHz crystal clock, never from a PLL output. It sequences PLL reset and the dynamic divider selects, qualifies lock with a timeout, a retry limit and a stability filter, and releases a reset for the downstream video domain. It also accepts runtime divider reconfiguration for video-mode changes through a valid/ready handshake.

Parameters:
RESET_HOLD_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 2700000, cycles allowed in WAIT_LOCK per attempt (100 ms)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised lock cycles required before RUN
MAX_RETRIES, 3, failed attempts before FAULT (1..3)
INIT_IDIV, 8, reset value of the input divider field
INIT_FBDIV, 63, reset value of the feedback divider field
INIT_ODIV, 4, reset value of the output divider field

Ports:
clk  in  1  27 MHz crystal clock
rst_n  in  1  asynchronous, active-low reset
pll_lock  in  1  PLL lock, asynchronous; 2-FF synchronised internally (lock_s)
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  reconfiguration accept
cfg_idiv  in  6  new input divider field
cfg_fbdiv  in  6  new feedback divider field
cfg_odiv  in  6  new output divider field
pll_reset  out  1  PLL RESET
pll_idsel  out  6  PLL IDSEL
pll_fbdsel  out  6  PLL FBDSEL
pll_odsel  out  6  PLL ODSEL
clk_ok  out  1  PLL locked and stable
dom_rst_n  out  1  downstream domain reset, active-low; re-synchronised by the consumer
fault  out  1  retries exhausted
retry_cnt  out  2  failed attempts in the current sequence

Behaviour:
- All outputs are registered. A condition sampled at edge N takes effect at edge N+1. lock_s lags pll_lock by 2 edges.
- Select encoding: pll_*sel = ~field (6'h3F - field). Fields are held in internal registers.
- Reset values (asynchronous): state=HOLD, pll_reset=1, fields=INIT_*, so selects = ~INIT_* (idsel 6'h37, fbdsel 6'h00, odsel 6'h3B). cfg_ready=0, clk_ok=0, dom_rst_n=0, fault=0, retry_cnt=0, counters=0.
- HOLD: pll_reset=1; count to RESET_HOLD_CYCLES, then go to WAIT_LOCK with pll_reset=0 and the timer cleared.
- WAIT_LOCK:
  - lock_s=1 -> STABLE with the stability counter cleared.
  - Timer reaches LOCK_TIMEOUT_CYCLES -> retry_cnt+1. If the new value equals MAX_RETRIES -> FAULT, otherwise -> HOLD.
- STABLE: count consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK with the timer restarted and no retry increment.
  - Count reaches LOCK_STABLE_CYCLES -> RUN.
- RUN: clk_ok=1, dom_rst_n=1, cfg_ready=1, retry_cnt cleared.
  - lock_s=0 -> HOLD; clk_ok=0 and dom_rst_n=0 at the same edge that raises pll_reset.
- FAULT: fault=1, pll_reset=1, cfg_ready=1, clk_ok=0, dom_rst_n=0. Stays here until a cfg handshake.
- cfg handshake = cfg_valid & cfg_ready, accepted only in RUN or FAULT. At that edge:
  - latch cfg_* into the fields;
  - pll_reset=1, clk_ok=0, dom_rst_n=0, cfg_ready=0, fault=0, retry_cnt=0;
  - go to HOLD.
  - Selects therefore change only in the edge that raises pll_reset.
- Simultaneous handshake and lock loss in RUN: the handshake wins and new fields are latched; the next state is HOLD either way.
- cfg_valid outside RUN/FAULT is ignored; cfg_ready=0 there. Requesters hold cfg_valid until accepted.
- clk_ok and dom_rst_n are always equal. They are 1 only in RUN.
- Counter widths come from $clog2 of each parameter. Counters saturate and never wrap.
- rst_n asserted in any state returns all outputs to reset values immediately, with no clock edge needed.

Test Plan:
- Set RESET_HOLD=4, TIMEOUT=50, STABLE=8, MAX_RETRIES=3 for all scenarios.
- Power-up: release rst_n; model raises pll_lock 10 cycles after pll_reset falls -> pll_reset high 4 cycles after release; clk_ok=dom_rst_n=1 exactly 2+8+1 edges after pll_lock rises; selects 6'h37/6'h00/6'h3B throughout.
- Lock never rises -> three pll_reset pulses, each 4 cycles, separated by 50-cycle waits; retry_cnt 1, 2, then fault=1 with pll_reset held 1 and cfg_ready=1.
- Lock glitch low for 1 cycle at stability count 5 -> stability counter restarts; clk_ok rises only after 8 further consecutive lock_s cycles; retry_cnt stays 0.
- In RUN, cfg_valid with idiv=3, fbdiv=19, odiv=8 -> accepted in one cycle; next edge pll_reset=1, selects 6'h3C/6'h2C/6'h37, clk_ok=0, dom_rst_n=0; relock reaches RUN.
- From FAULT, apply a cfg handshake -> fault=0, retry_cnt=0, full sequence reruns; lock loss in RUN -> clk_ok=0 within 3 edges.
- Assert rst_n mid-WAIT_LOCK with the clock stopped -> pll_reset=1 and clk_ok=0 immediately; fields return to INIT_*.
